data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Responder side of the CPU data-memory interface: accepts the word address, write data and read/write strobes from the MEM stage and drives a synchronous block RAM.
- Registers every request before it reaches the BRAM, hides the BRAM read latency behind a stall signal, and flags bad accesses.
- Sits between the MEM stage and the data BRAM; the CPU pipeline holds the request stable while mem_stall is high.

Parameters:
- BRAM_AW, 14, BRAM word-address width (depth = 2^BRAM_AW 32-bit words).
- RD_LAT, 2, BRAM read latency in cycles from bram_en to valid bram_rdata; legal range 1..4.
- BASE_ADDR, 32'h0000_0000, byte address mapped to BRAM word 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_addr  in  32  byte address from the MEM stage.
- mem_wdata  in  32  store data.
- mem_rd  in  1  load request.
- mem_wr  in  1  store request.
- mem_rdata  out  32  load data, registered.
- mem_stall  out  1  pipeline hold; request must stay stable while high.
- mem_err  out  1  one-cycle error pulse (misaligned, out of range, or rd&wr together).
- bram_en  out  1  BRAM enable.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  BRAM_AW  BRAM word address, registered.
- bram_wdata  out  32  BRAM write data, registered.
- bram_rdata  in  32  BRAM read data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; latency counter=0.
  - mem_rdata=0, mem_err=0, bram_en=0, bram_we=0, bram_addr=0, bram_wdata=0.
  - mem_stall is 0 while in reset.
  - Reset mid-transaction abandons the access; no BRAM write completes after reset asserts.
- Address check, combinational, in IDLE:
  - off = mem_addr - BASE_ADDR, 32-bit wrap.
  - Bad access if off[1:0]!=0, off >= 4*2^BRAM_AW, or mem_rd&mem_wr.
  - bram_addr = off[BRAM_AW+1:2].
- States: IDLE, WRITE, ISSUE, WAIT, RESP, ERR.
- IDLE:
  - No request: mem_stall=0; stay in IDLE.
  - Bad request: mem_stall=1; go to ERR; no BRAM activity.
  - Good write: mem_stall=1; register bram_addr and bram_wdata; go to WRITE.
  - Good read: mem_stall=1; register bram_addr; go to ISSUE.
- WRITE: bram_en=1, bram_we=1, mem_stall=0; go to IDLE. A store takes 2 cycles.
- ISSUE: bram_en=1, bram_we=0, mem_stall=1; counter=RD_LAT-1.
  - RD_LAT==1: go to RESP.
  - Otherwise: go to WAIT.
- WAIT: mem_stall=1; decrement counter; when counter==1 go to RESP.
- RESP: mem_rdata<=bram_rdata, visible from the next edge; mem_stall=0; go to IDLE.
  - A load takes 2+RD_LAT cycles of stall+release.
  - The value is captured on the RESP edge. The CPU samples it in the cycle after RESP, i.e. from the MEM/WB register.
- ERR: mem_err=1 for exactly one cycle, mem_stall=0, mem_rdata<=0; go to IDLE.
- mem_rdata holds its last value except in RESP and ERR.
- bram_en and bram_we are 0 in every state not listed above.
- Back-to-back requests: the next request is first sampled in IDLE, the cycle after WRITE/RESP/ERR. No overlap; one outstanding access at most.
- Requests arriving outside IDLE are ignored; the protocol requires them to be held anyway.

Decomposition:
- Package data_mem_ctrl_pkg holds:
  - the state enum (IDLE, WRITE, ISSUE, WAIT, RESP, ERR), 3-bit encoding;
  - the word width constant WORD_W=32;
  - the alignment mask constant.
- One sub-module is natural: mem_addr_check, purely combinational. It computes off, bram_addr, bad_align, bad_range and bad_both from mem_addr, mem_rd, mem_wr and the parameters. All sequencing stays in data_mem_ctrl.

Test Plan:
- Store then load, RD_LAT=2: mem_wr=1, mem_addr=0x0000_0010, mem_wdata=0xDEADBEEF.
  - Expect stall=1 for 1 cycle, then bram_we=1 with bram_addr=4.
  - Then a load of 0x10: stall=1 for 3 cycles; mem_rdata=0xDEADBEEF after RESP; total 4 cycles.
- RD_LAT=1 and RD_LAT=4 builds: load from a preloaded word. Expect stall-high cycles of 2 and 5 respectively, with correct data.
- Misaligned load at 0x0000_0006: one cycle stall, then mem_err=1 for one cycle, mem_rdata=0, bram_en never asserted.
- Out of range: BASE_ADDR=0x1000_0000, load at 0x0FFF_FFFC (wraps to a large offset) and at 0x1001_0000 with BRAM_AW=14. Both give mem_err; neither enables the BRAM.
- mem_rd=1 and mem_wr=1 together at 0x20: mem_err pulse, bram_we stays 0, memory contents unchanged.
- rst_n dropped in the WAIT state of a load: all outputs 0 immediately and state IDLE. After release, a new store to 0x8 completes normally in 2 cycles.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_ctrl_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] ALIGN_MASK = 32'h0000_0003;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4,
    ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/mem_addr_check.sv
// Maps a CPU byte address onto a BRAM word address and classifies bad accesses.
module mem_addr_check
  import data_mem_ctrl_pkg::*;
#(
  parameter int          BRAM_AW   = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic [WORD_W-1:0]  mem_addr,
  input  logic               mem_rd,
  input  logic               mem_wr,
  output logic [BRAM_AW-1:0] bram_addr,
  output logic               bad_align,
  output logic               bad_range,
  output logic               bad_both
);

  logic [WORD_W-1:0] off;

  // Wrapping subtraction: addresses below BASE_ADDR become huge offsets and fail the range test.
  assign off       = mem_addr - BASE_ADDR;
  assign bram_addr = off[BRAM_AW+1:2];
  assign bad_align = (off & ALIGN_MASK) != '0;
  assign bad_range = off[WORD_W-1:BRAM_AW+2] != '0;
  assign bad_both  = mem_rd & mem_wr;

endmodule

// File: rtl/data_mem_ctrl.sv
// Responder for the CPU data-memory port: registers each request into a synchronous
// BRAM, stalls the pipeline across the read latency and pulses mem_err on bad accesses.
//
// state | meaning
// IDLE  | sample request; stall combinationally while one is present
// WRITE | BRAM write strobe, release the pipeline
// ISSUE | BRAM read strobe, load latency counter
// WAIT  | count down remaining read latency
// RESP  | capture bram_rdata into mem_rdata, release
// ERR   | one-cycle mem_err pulse, clear mem_rdata, release
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int          BRAM_AW   = 14,
  parameter int          RD_LAT    = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WORD_W-1:0]  mem_addr,
  input  logic [WORD_W-1:0]  mem_wdata,
  input  logic               mem_rd,
  input  logic               mem_wr,
  output logic [WORD_W-1:0]  mem_rdata,
  output logic               mem_stall,
  output logic               mem_err,
  output logic               bram_en,
  output logic               bram_we,
  output logic [BRAM_AW-1:0] bram_addr,
  output logic [WORD_W-1:0]  bram_wdata,
  input  logic [WORD_W-1:0]  bram_rdata
);

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  state_t             state;
  logic [2:0]         lat_cnt;
  logic [BRAM_AW-1:0] chk_addr;
  logic               bad_align;
  logic               bad_range;
  logic               bad_both;
  logic               req;
  logic               bad;

  mem_addr_check #(
    .BRAM_AW  (BRAM_AW),
    .BASE_ADDR(BASE_ADDR)
  ) u_addr_check (
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .bram_addr(chk_addr),
    .bad_align(bad_align),
    .bad_range(bad_range),
    .bad_both (bad_both)
  );

  assign req = mem_rd | mem_wr;
  assign bad = bad_align | bad_range | bad_both;

  // The IDLE stall must react in the same cycle the request appears, so it is not registered.
  assign mem_stall = (state == IDLE) ? (rst_n & req) : ((state == ISSUE) || (state == WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      mem_rdata  <= '0;
      mem_err    <= 1'b0;
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
    end else begin
      bram_en <= 1'b0;
      bram_we <= 1'b0;
      mem_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (bad) begin
              state   <= ERR;
              mem_err <= 1'b1;
            end else if (mem_wr) begin
              state      <= WRITE;
              bram_addr  <= chk_addr;
              bram_wdata <= mem_wdata;
              bram_en    <= 1'b1;
              bram_we    <= 1'b1;
            end else begin
              state     <= ISSUE;
              bram_addr <= chk_addr;
              bram_en   <= 1'b1;
            end
          end
        end
        WRITE: state <= IDLE;
        ISSUE: begin
          lat_cnt <= LAT_LOAD;
          state   <= (RD_LAT == 1) ? RESP : WAIT;
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) state <= RESP;
        end
        RESP: begin
          mem_rdata <= bram_rdata;
          state     <= IDLE;
        end
        ERR: begin
          mem_rdata <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl: three builds (RD_LAT 2/1/4, two base addresses)
// each against a behavioural BRAM and an access-level reference model.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_done = 0;

  always #5 clk = ~clk;

  task automatic check(input int inst, input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL c%0d %s: got %h expected %h", inst, tag, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'h5EED_0000 ^ (32'(i) * 32'h9E37_79B9);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u_cfg
    localparam int          L = (g == 1) ? 1 : (g == 2) ? 4 : 2;
    localparam logic [31:0] B = (g == 2) ? 32'h1000_0000 : 32'h0000_0000;

    logic        rst_n = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic        mem_rd = 1'b0, mem_wr = 1'b0;
    logic [31:0] mem_rdata, bram_wdata, bram_rdata;
    logic        mem_stall, mem_err, bram_en, bram_we;
    logic [13:0] bram_addr;

    data_mem_ctrl #(.BRAM_AW(14), .RD_LAT(L), .BASE_ADDR(B)) dut (
      .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
      .mem_err(mem_err), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
    );

    // Synchronous BRAM with L-cycle read latency; filler value when no read is issued.
    logic [31:0] bram [0:16383];
    logic [31:0] rd_pipe [0:L-1];
    bit          loaded = 1'b0;
    always @(posedge clk) begin
      if (!loaded) begin
        for (int i = 0; i < 16384; i++) bram[i] <= init_word(i);
        loaded <= 1'b1;
      end else if (bram_en && bram_we) bram[bram_addr] <= bram_wdata;
      rd_pipe[0] <= (bram_en && !bram_we) ? bram[bram_addr] : 32'hA5A5_5A5A;
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_rdata = rd_pipe[L-1];

    logic [31:0] model_mem [int];
    logic [31:0] exp_rdata = '0;

    function automatic logic [31:0] model_read(input int w);
      return model_mem.exists(w) ? model_mem[w] : init_word(w);
    endfunction

    // Present one request at posedge+1, follow it to release, check against the model.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] off, en_addr, en_wd;
      bit bad, rel;
      int w, n_st, n_en, n_we, exp_st;
      off = a - B;
      bad = (off[1:0] != 2'b00) || (off >= 32'h0001_0000) || (rd && wr);
      w = int'(off[15:2]);
      mem_rd = rd; mem_wr = wr; mem_addr = a; mem_wdata = wd;
      if (!rd && !wr) begin
        @(negedge clk);
        check(g, "idle_stall", 32'(mem_stall), 0);
        @(posedge clk); #1;
        return;
      end
      rel = 0; n_st = 0; n_en = 0; n_we = 0; en_addr = '0; en_wd = '0;
      for (int c = 0; c < 20 && !rel; c++) begin
        @(negedge clk);
        if (bram_en) begin n_en++; en_addr = 32'(bram_addr); en_wd = bram_wdata; end
        if (bram_we) n_we++;
        if (mem_stall) n_st++;
        else begin rel = 1; check(g, "err_at_release", 32'(mem_err), 32'(bad)); end
        @(posedge clk); #1;
      end
      mem_rd = 0; mem_wr = 0;
      check(g, "released", 32'(rel), 1);
      exp_st = bad ? 1 : wr ? 1 : L + 1;
      check(g, "stall_cycles", 32'(n_st), 32'(exp_st));
      check(g, "en_cycles", 32'(n_en), bad ? 0 : 1);
      check(g, "we_cycles", 32'(n_we), (!bad && wr) ? 1 : 0);
      if (!bad) check(g, "bram_addr", en_addr, 32'(w));
      if (!bad && wr) begin
        check(g, "bram_wdata", en_wd, wd);
        model_mem[w] = wd;
      end
      if (bad) exp_rdata = '0;
      else if (rd) exp_rdata = model_read(w);
      check(g, "mem_rdata", mem_rdata, exp_rdata);
      check(g, "err_cleared", 32'(mem_err), 0);
    endtask

    initial begin
      logic [31:0] a;
      int r, w;
      mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 32'h6;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check(g, "rst_stall", 32'(mem_stall), 0);
      check(g, "rst_ctl", {28'h0, bram_en, bram_we, mem_err, mem_stall}, 0);
      check(g, "rst_rdata", mem_rdata, 0);
      check(g, "rst_baddr", 32'(bram_addr), 0);
      check(g, "rst_bwdata", bram_wdata, 0);
      mem_rd = 1'b0; mem_wr = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      if (g == 0) begin
        access(0, 1, 32'h0000_0010, 32'hDEAD_BEEF);
        access(1, 0, 32'h0000_0010, 32'h0);
        check(g, "store_load_data", mem_rdata, 32'hDEAD_BEEF);
        access(1, 0, 32'h0000_0006, 32'h0);
        access(1, 1, 32'h0000_0020, 32'h1234_5678);
        access(1, 0, 32'h0000_0020, 32'h0);
        check(g, "both_no_write", mem_rdata, init_word(8));
        // Reset while the load sits in WAIT.
        mem_rd = 1'b1; mem_addr = 32'h0000_0010;
        @(negedge clk); @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
        check(g, "in_wait_stall", 32'(mem_stall), 1);
        rst_n = 1'b0; #1;
        check(g, "midrst_ctl", {28'h0, bram_en, bram_we, mem_err, mem_stall}, 0);
        check(g, "midrst_rdata", mem_rdata, 0);
        check(g, "midrst_baddr", 32'(bram_addr), 0);
        mem_rd = 1'b0; exp_rdata = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        access(0, 1, 32'h0000_0008, 32'hCAFE_F00D);
        access(1, 0, 32'h0000_0008, 32'h0);
      end else if (g == 1) begin
        access(1, 0, 32'h0000_0040, 32'h0);
        check(g, "preload_data", mem_rdata, init_word(16));
      end else begin
        access(1, 0, 32'h1000_0040, 32'h0);
        check(g, "preload_data", mem_rdata, init_word(16));
        access(1, 0, 32'h0FFF_FFFC, 32'h0);
        access(1, 0, 32'h1001_0000, 32'h0);
      end

      for (int n = 0; n < 40; n++) begin
        r = $urandom_range(0, 9);
        w = ($urandom_range(0, 7) == 0) ? 16383 : $urandom_range(0, 31);
        a = B + 32'(w) * 4;
        case (r)
          0:       access(0, 0, a, 32'h0);
          1, 2, 3: access(1, 0, a, 32'h0);
          4, 5, 6: access(0, 1, a, $urandom);
          7:       access(1, 0, a + 32'($urandom_range(1, 3)), 32'h0);
          8:       access(0, 1, ($urandom_range(0, 1) == 1) ? B - 32'h4 : B + 32'h0001_0000 + 32'(w) * 4, $urandom);
          default: access(1, 1, a, $urandom);
        endcase
      end
      n_done++;
    end
  end

  initial begin
    for (int c = 0; c < 40000 && n_done < 3; c++) @(posedge clk);
    check(9, "all_done", 32'(n_done), 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
